// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module  : if_stage_pkg
// Brief   : Shared widths, stall encodings and reset PC for the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int          STALL_W     = 6;
  localparam int          BR_WD       = 33;
  localparam int          IF_TO_ID_WD = 33;
  localparam logic        STOP        = 1'b1;
  localparam logic        NO_STOP     = 1'b0;
  localparam logic [31:0] RESET_PC    = 32'hBFBF_FFFC;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

endpackage

`default_nettype wire

// File: rtl/if_stage_pc_reg.sv
// ============================================================================
// Module  : if_stage_pc_reg
// Brief   : PC/CE registers and next-PC mux; drives the SRAM fetch request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_pc_reg
  import if_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_pc,
  input  logic [BR_WD-1:0] br_bus,
  output logic [31:0]      pc,
  output logic             ce,
  output logic [31:0]      fetch_addr,
  output logic             fetch_en
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;
  logic [31:0] pc_d, pc_q;
  logic        ce_d, ce_q;

  assign {br_e, br_addr} = br_bus;

  always_comb begin
    next_pc = br_e ? br_addr : pc_q + 32'd4;
    pc_d    = pc_q;
    ce_d    = ce_q;
    if (rst) begin
      pc_d = RESET_PC;
      ce_d = 1'b0;
    end else if (stall_pc == NO_STOP) begin
      pc_d = next_pc;
      ce_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    ce_q <= ce_d;
  end

  // While the PC is frozen the current PC is re-issued so the synchronous
  // SRAM keeps returning the instruction that matches the held PC.
  assign fetch_addr = (stall_pc == NO_STOP) ? next_pc : pc_q;
  assign fetch_en   = ~rst;
  assign pc         = pc_q;
  assign ce         = ce_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Brief   : Instruction fetch stage with optional instruction hold buffer
//           (enabled by defining IF_INST_BUF_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            if_inst,
  output logic                   if_inst_valid
);

  logic [31:0] pc;
  logic        ce;
  logic [31:0] inst_raw;
  logic        bubble;
  logic        unused_stall_bits;

  if_stage_pc_reg u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .stall_pc   (stall[0]),
    .br_bus     (br_bus),
    .pc         (pc),
    .ce         (ce),
    .fetch_addr (inst_sram_addr),
    .fetch_en   (inst_sram_en)
  );

`ifdef IF_INST_BUF_EN
  hold_state_e state_d, state_q;
  logic [31:0] hold_d, hold_q;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    hold_q  <= hold_d;
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    inst_raw = (state_q == ST_HOLD) ? hold_q : inst_sram_rdata;
    if (rst) begin
      state_d = ST_RUN;
      hold_d  = 32'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stall[2] == STOP) begin
            state_d = ST_HOLD;
            hold_d  = inst_raw;
          end
        end
        ST_HOLD: begin
          if (stall[2] == NO_STOP) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end
`else
  assign inst_raw = inst_sram_rdata;
`endif

  // IF->ID frozen while ID advances: hand ID a nop bubble instead.
  assign bubble = (stall[1] == STOP) && (stall[2] == NO_STOP);

  assign if_inst         = bubble ? 32'b0 : inst_raw;
  assign if_inst_valid   = ce & ~rst & ~bubble;
  assign if_to_id_bus    = {ce, pc};
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'b0;

  assign unused_stall_bits = ^stall[STALL_W-1:3];

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Brief   : Self-checking bench for if_stage with a scoreboard of fetches.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;
  import if_stage_pkg::*;

`ifdef IF_INST_BUF_EN
  localparam bit HAS_BUF = 1'b1;
`else
  localparam bit HAS_BUF = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'b0;
  logic [32:0] br_bus = 33'b0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;
  logic        if_inst_valid;

  logic [31:0] sram_q  = 32'b0;
  logic        ovr_en  = 1'b0;
  logic [31:0] ovr_val = 32'b0;

  fetch_t      sb[$];
  fetch_t      cur;
  logic [31:0] m_pc;
  logic [31:0] m_pc_next = RESET_PC;
  logic [31:0] exp_addr;
  logic        pushed_last = 1'b0;
  logic        new_fetch   = 1'b0;
  logic [31:0] p_saved;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .if_to_id_bus    (if_to_id_bus),
    .if_inst         (if_inst),
    .if_inst_valid   (if_inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_model(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]};
  endfunction

  always @(posedge clk) begin
    if (inst_sram_en) sram_q <= sram_model(inst_sram_addr);
  end
  assign inst_sram_rdata = ovr_en ? ovr_val : sram_q;

  // Drives one cycle and keeps the reference PC model and scoreboard in step.
  task automatic drive(input logic r, input logic [5:0] s, input logic be,
                       input logic [31:0] ba, input logic oe, input logic [31:0] ov);
    @(negedge clk);
    m_pc      = m_pc_next;
    new_fetch = 1'b0;
    if (!r && pushed_last && sb.size() != 0) begin
      cur       = sb.pop_front();
      new_fetch = 1'b1;
    end
    rst     = r;
    stall   = s;
    br_bus  = {be, ba};
    ovr_en  = oe;
    ovr_val = ov;
    #1;
    if (r) begin
      sb.delete();
      pushed_last = 1'b0;
      exp_addr    = m_pc + 32'd4;
      m_pc_next   = RESET_PC;
    end else if (!s[0]) begin
      exp_addr = be ? ba : m_pc + 32'd4;
      sb.push_back('{pc: exp_addr, inst: sram_model(exp_addr)});
      pushed_last = 1'b1;
      m_pc_next   = exp_addr;
    end else begin
      exp_addr    = m_pc;
      pushed_last = 1'b0;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (inst_sram_en !== 1'b0) begin
        errors++; $display("FAIL reset_en cyc%0d: got %b want 0", i, inst_sram_en);
      end
      checks++;
      if (if_inst_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid cyc%0d: got %b want 0", i, if_inst_valid);
      end
      if (i > 0) begin
        checks++;
        if (if_to_id_bus !== {1'b0, RESET_PC}) begin
          errors++; $display("FAIL reset_bus cyc%0d: got %h want %h", i, if_to_id_bus, {1'b0, RESET_PC});
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (inst_sram_addr !== 32'hBFC0_0000 + 32'(4 * i) || inst_sram_en !== 1'b1) begin
        errors++; $display("FAIL boot_addr cyc%0d: got %h en %b want %h en 1", i, inst_sram_addr, inst_sram_en, 32'hBFC0_0000 + 32'(4 * i));
      end
      checks++;
      if (inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin
        errors++; $display("FAIL sram_wr_const: got wen %h wdata %h want 0 0", inst_sram_wen, inst_sram_wdata);
      end
      if (i == 0) begin
        checks++;
        if (if_to_id_bus !== {1'b0, RESET_PC} || if_inst_valid !== 1'b0) begin
          errors++; $display("FAIL boot_first: got bus %h valid %b want %h valid 0", if_to_id_bus, if_inst_valid, {1'b0, RESET_PC});
        end
      end else begin
        checks++;
        if (if_to_id_bus !== {1'b1, cur.pc} || if_inst !== cur.inst || if_inst_valid !== 1'b1) begin
          errors++; $display("FAIL boot_fetch cyc%0d: got bus %h inst %h valid %b want bus %h inst %h valid 1",
                             i, if_to_id_bus, if_inst, if_inst_valid, {1'b1, cur.pc}, cur.inst);
        end
      end
    end
  endtask

  task automatic test_branch;
    // Branch at 0xBFC00010 resolves in ID while its delay slot is in IF.
    for (int i = 0; i < 3; i++) drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (if_to_id_bus !== {1'b1, 32'hBFC0_0010}) begin
      errors++; $display("FAIL br_pc: got %h want %h", if_to_id_bus, {1'b1, 32'hBFC0_0010});
    end
    drive(1'b0, 6'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0);
    checks++;
    if (if_to_id_bus !== {1'b1, 32'hBFC0_0014} || if_inst !== cur.inst || if_inst_valid !== 1'b1) begin
      errors++; $display("FAIL br_delay_slot: got bus %h inst %h valid %b want bus %h inst %h valid 1",
                         if_to_id_bus, if_inst, if_inst_valid, {1'b1, 32'hBFC0_0014}, cur.inst);
    end
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0100) begin
      errors++; $display("FAIL br_addr: got %h want %h", inst_sram_addr, 32'hBFC0_0100);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (if_to_id_bus !== {1'b1, 32'hBFC0_0100} || if_inst !== cur.inst) begin
      errors++; $display("FAIL br_target: got bus %h inst %h want bus %h inst %h",
                         if_to_id_bus, if_inst, {1'b1, 32'hBFC0_0100}, cur.inst);
    end
  endtask

  task automatic test_bubble;
    drive(1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
    p_saved = cur.pc;
    checks++;
    if (if_inst !== 32'b0 || if_inst_valid !== 1'b0 || inst_sram_addr !== p_saved) begin
      errors++; $display("FAIL bubble: got inst %h valid %b addr %h want inst 0 valid 0 addr %h",
                         if_inst, if_inst_valid, inst_sram_addr, p_saved);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (if_to_id_bus !== {1'b1, p_saved} || if_inst !== cur.inst || if_inst_valid !== 1'b1) begin
      errors++; $display("FAIL bubble_after: got bus %h inst %h valid %b want bus %h inst %h valid 1",
                         if_to_id_bus, if_inst, if_inst_valid, {1'b1, p_saved}, cur.inst);
    end
    checks++;
    if (inst_sram_addr !== p_saved + 32'd4) begin
      errors++; $display("FAIL bubble_next_addr: got %h want %h", inst_sram_addr, p_saved + 32'd4);
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 6'b000111, 1'b0, 32'h0, 1'b1, 32'h2401_0001);
    p_saved = cur.pc;
    checks++;
    if (if_inst !== 32'h2401_0001 || inst_sram_addr !== p_saved) begin
      errors++; $display("FAIL hold_entry: got inst %h addr %h want inst 24010001 addr %h", if_inst, inst_sram_addr, p_saved);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 6'b000111, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      checks++;
      if (if_inst !== (HAS_BUF ? 32'h2401_0001 : 32'hDEAD_BEEF) || if_to_id_bus !== {1'b1, p_saved}) begin
        errors++; $display("FAIL hold_stable cyc%0d: got inst %h bus %h want inst %h bus %h", i, if_inst, if_to_id_bus,
                           HAS_BUF ? 32'h2401_0001 : 32'hDEAD_BEEF, {1'b1, p_saved});
      end
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (if_inst !== (HAS_BUF ? 32'h2401_0001 : cur.inst) || inst_sram_addr !== p_saved + 32'd4) begin
      errors++; $display("FAIL hold_release: got inst %h addr %h want inst %h addr %h", if_inst, inst_sram_addr,
                         HAS_BUF ? 32'h2401_0001 : cur.inst, p_saved + 32'd4);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (if_to_id_bus !== {1'b1, p_saved + 32'd4} || if_inst !== cur.inst || if_inst_valid !== 1'b1) begin
      errors++; $display("FAIL hold_next: got bus %h inst %h valid %b want bus %h inst %h valid 1",
                         if_to_id_bus, if_inst, if_inst_valid, {1'b1, p_saved + 32'd4}, cur.inst);
    end
  endtask

  task automatic test_branch_stall;
    drive(1'b0, 6'b000001, 1'b1, 32'h1FC0_0200, 1'b0, 32'h0);
    p_saved = cur.pc;
    checks++;
    if (inst_sram_addr !== p_saved) begin
      errors++; $display("FAIL brstall_addr: got %h want %h", inst_sram_addr, p_saved);
    end
    drive(1'b0, 6'b000001, 1'b1, 32'h1FC0_0200, 1'b0, 32'h0);
    checks++;
    if (if_to_id_bus !== {1'b1, p_saved} || inst_sram_addr !== p_saved) begin
      errors++; $display("FAIL brstall_hold: got bus %h addr %h want pc %h", if_to_id_bus, inst_sram_addr, p_saved);
    end
    drive(1'b0, 6'b0, 1'b1, 32'h1FC0_0200, 1'b0, 32'h0);
    checks++;
    if (inst_sram_addr !== 32'h1FC0_0200) begin
      errors++; $display("FAIL brstall_release_addr: got %h want 1fc00200", inst_sram_addr);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (if_to_id_bus !== {1'b1, 32'h1FC0_0200} || if_inst !== cur.inst) begin
      errors++; $display("FAIL brstall_target: got bus %h inst %h want bus %h inst %h",
                         if_to_id_bus, if_inst, {1'b1, 32'h1FC0_0200}, cur.inst);
    end
  endtask

  task automatic test_wrap;
    drive(1'b0, 6'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (inst_sram_addr !== 32'h0000_0000 || if_to_id_bus !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap: got addr %h bus %h want addr 0 bus %h", inst_sram_addr, if_to_id_bus, {1'b1, 32'hFFFF_FFFC});
    end
    drive(1'b0, 6'b0, 1'b1, 32'h0000_1002, 1'b0, 32'h0);
    checks++;
    if (inst_sram_addr !== 32'h0000_1002) begin
      errors++; $display("FAIL misaligned_addr: got %h want 00001002", inst_sram_addr);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (inst_sram_addr !== 32'h0000_1006 || if_to_id_bus !== {1'b1, 32'h0000_1002}) begin
      errors++; $display("FAIL misaligned_next: got addr %h bus %h want addr 00001006 bus %h",
                         inst_sram_addr, if_to_id_bus, {1'b1, 32'h0000_1002});
    end
  endtask

  task automatic test_reset_in_hold;
    drive(1'b0, 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 6'b000111, 1'b1, 32'h1234_0000, 1'b0, 32'h0);
    checks++;
    if (inst_sram_en !== 1'b0 || if_inst_valid !== 1'b0) begin
      errors++; $display("FAIL rsthold_cycle: got en %b valid %b want 0 0", inst_sram_en, if_inst_valid);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h1111_2222);
    checks++;
    if (if_to_id_bus !== {1'b0, RESET_PC} || if_inst_valid !== 1'b0 || inst_sram_addr !== 32'hBFC0_0000) begin
      errors++; $display("FAIL rsthold_after: got bus %h valid %b addr %h want bus %h valid 0 addr bfc00000",
                         if_to_id_bus, if_inst_valid, inst_sram_addr, {1'b0, RESET_PC});
    end
    checks++;
    if (if_inst !== 32'h1111_2222) begin
      errors++; $display("FAIL rsthold_run: got inst %h want 11112222", if_inst);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (if_to_id_bus !== {1'b1, 32'hBFC0_0000} || if_inst !== cur.inst || if_inst_valid !== 1'b1) begin
      errors++; $display("FAIL rsthold_restart: got bus %h inst %h valid %b want bus %h inst %h valid 1",
                         if_to_id_bus, if_inst, if_inst_valid, {1'b1, 32'hBFC0_0000}, cur.inst);
    end
  endtask

  initial begin
    test_reset;
    test_branch;
    test_bubble;
    test_hold;
    test_branch_stall;
    test_wrap;
    test_reset_in_hold;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 stall  input  6 (StallBus)  stall[0] freezes PC, stall[1] freezes IF->ID register, stall[2] freezes ID; Stop=1, NoStop=0.
REQ-004 br_bus  input  33 (BR_WD)  {br_e, br_addr[31:0]} from ID; redirect request.
REQ-005 inst_sram_en  output  1  fetch enable.
REQ-006 inst_sram_wen  output  4  byte write enables; constant 4'b0000.
REQ-007 inst_sram_addr  output  32  fetch address.
REQ-008 inst_sram_wdata  output  32  constant 32'b0.
REQ-009 inst_sram_rdata  input  32  instruction; synchronous SRAM, data for address presented in cycle N valid in cycle N+1.
REQ-010 if_to_id_bus  output  33 (IF_TO_ID_WD)  {ce, pc[31:0]} of instruction now fetched.
REQ-011 if_inst  output  32  instruction matching if_to_id_bus pc, held stable while ID stalled.
REQ-012 if_inst_valid  output  1  if_inst is a real instruction (0 = bubble).

Function
REQ-013 next_pc: br_e ? br_addr : pc+4; 32-bit add, wrap at 0xFFFF_FFFC with no flag.
REQ-014 pc/ce update only when stall[0]==NoStop; on update pc<=next_pc, ce<=1.
REQ-015 br_bus sampled only in cycles with stall[0]==NoStop; br_e while stall[0]==Stop is ignored (ID re-presents it after release).
REQ-016 inst_sram_en = ce_next, where ce_next = 0 in rst cycle, else 1; inst_sram_addr = next_pc when stall[0]==NoStop, else pc-held fetch address (same address re-issued).
REQ-017 Holding FSM, states RUN, HOLD.
REQ-018 RUN: if_inst = inst_sram_rdata, if_inst_valid = ce.
REQ-019 RUN->HOLD on edge where stall[2]==Stop; hold_reg <= if_inst of that cycle.
REQ-020 HOLD: if_inst = hold_reg; stays HOLD while stall[2]==Stop.
REQ-021 HOLD->RUN on edge where stall[2]==NoStop; the first RUN cycle delivers SRAM data for the pc following the held instruction.
REQ-022 stall[1]==Stop and stall[2]==NoStop: if_inst=32'b0 (nop), if_inst_valid=0 for that cycle; no state change.
REQ-023 Branch delay slot: instruction at pc+4 of a branch always delivered; no flush of fetched instruction.
REQ-024 br_e and stall[0] release in same cycle: redirect taken, stall release honoured.
REQ-025 inst_sram_addr[1:0] always 2'b00 given aligned br_addr; misaligned br_addr passed through unchanged.

Reset
REQ-026 rst: pc<=32'hBFBF_FFFC, ce<=0, FSM<=RUN, hold_reg<=0.
REQ-027 During reset cycle: inst_sram_en=0, if_inst_valid=0, if_to_id_bus={1'b0, 32'hBFBF_FFFC}.
REQ-028 First cycle after rst deasserts: inst_sram_addr=32'hBFC0_0000, inst_sram_en=1; next cycle pc=32'hBFC0_0000, ce=1.
REQ-029 rst mid-stall or mid-HOLD overrides everything; stall and br_bus ignored in reset cycle.

Configuration
REQ-030 Macro IF_INST_BUF_EN: defined -> HOLD FSM and hold_reg per REQ-017..021.
REQ-031 Not defined -> no FSM, if_inst = inst_sram_rdata always, if_inst_valid = ce (REQ-022 still applies); stall correctness then relies on SRAM address re-issue only.

Structure
REQ-032 StallBus, BR_WD, IF_TO_ID_WD, Stop/NoStop, reset PC constant 32'hBFBF_FFFC live in shared defines.vh.
REQ-033 One sub-module: pc_reg (pc, ce, next_pc mux); holding FSM stays in if_stage.

Verification
REQ-034 Reset 3 cycles, release, no stall -> inst_sram_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; ce=1 from second cycle.
REQ-035 pc=0xBFC00010, br_e=1 br_addr=0xBFC00100 -> next pc 0xBFC00100; delay slot 0xBFC00014 if_inst delivered.
REQ-036 stall=6'b000111 for 3 cycles with rdata=0x24010001 on entry, SRAM rdata changed to 0xDEADBEEF -> if_inst stays 0x24010001; after release, pc+4 instruction next.
REQ-037 stall=6'b000011 one cycle -> if_inst=0, if_inst_valid=0, pc unchanged.
REQ-038 br_e=1 with stall[0]=Stop -> pc unchanged; br_e=1 on release cycle -> redirect taken.
REQ-039 rst asserted while in HOLD -> next cycle pc=0xBFBFFFFC, ce=0, if_inst_valid=0, FSM RUN.
